au_seq: RTL and testbench
=========================

Name: au_seq

Overview:
- Sequencer stage directly upstream of the arithmetic unit (AU) in the 8-bit datapath.
- Accepts one operation request per transaction: 4-bit opcode plus two 8-bit operands, over a valid/ready handshake.
- Registers the request, drives the AU's enable, opcode and operand inputs for exactly one issue cycle, then captures the AU result byte and greater flag.
- Presents the captured result downstream over a second valid/ready handshake and keeps a running count of completed operations.

Parameters:
- CNT_W, 8, width of the completed-operation counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  request present.
- op_ready  output  1  sequencer can accept a request.
- op_code  input  4  AU opcode for the request.
- op_a  input  8  operand a.
- op_b  input  8  operand b.
- op_chain  input  1  use previous result as operand a (see Optional Feature).
- au_en  output  1  AU enable.
- au_ac  output  4  AU opcode.
- au_a  output  8  AU operand a.
- au_b  output  8  AU operand b.
- au_t  input  8  AU result; may be high-Z whenever au_en=0.
- au_gf  input  1  AU greater flag.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_t  output  8  captured result.
- res_gf  output  1  captured greater flag.
- res_err  output  1  request carried an unsupported opcode.
- op_cnt  output  CNT_W  completed-transaction count.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE; op_ready=1; au_en=0; au_ac=4'b0000; au_a=au_b=8'h00; res_valid=0; res_t=8'h00; res_gf=0; res_err=0; op_cnt=0.
- Reset asserted mid-operation aborts the transaction immediately. No partial result is presented. Counter is cleared.
- Supported opcodes:
  - 1000: add, t = a + b modulo 256.
  - 1001: subtract/compare, t = b - a modulo 256. gf=1 when b > a, signed by bit 7: same sign uses unsigned compare; b non-negative with a negative gives gf=1; b negative with a non-negative gives gf=0.
  - 0100, 0101, 1101: pass, t = a.
  - Any other opcode is unsupported.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - op_ready=1, au_en=0, au_ac=0000. au_a/au_b hold their last values.
  - On op_valid && op_ready at edge N: latch opcode and operands, load au_ac/au_a/au_b, go to ISSUE.
  - Supported opcode: au_en=1 in ISSUE. Unsupported opcode: au_en stays 0.
- ISSUE (cycle N+1):
  - op_ready=0.
  - At edge N+2, capture au_t into res_t and au_gf into res_gf, or load 8'h00/0 with res_err=1 for an unsupported opcode.
  - Set res_valid=1, clear au_en, set au_ac=0000, go to HOLD.
  - au_t is never sampled while au_en=0.
- HOLD:
  - res_valid, res_t, res_gf and res_err stay stable until res_ready=1.
  - On res_valid && res_ready: res_valid=0, res_err=0, op_cnt increments (also for error transactions), return to IDLE. op_ready=1 from the next cycle.
- Latency: request accept to res_valid is 2 cycles. Minimum request-to-request spacing is 3 cycles.
- op_valid while op_ready=0 is ignored. The requester holds it.
- res_ready while res_valid=0 has no effect.
- op_cnt wraps from all-ones to 0 with no flag.

Optional Feature:
- Macro: AU_SEQ_CHAIN_EN.
- Defined:
  - When op_chain=1 at accept, au_a loads the last captured res_t instead of op_a.
  - The last captured res_t is the most recent successful result. It is 8'h00 after reset and is not updated by error transactions.
  - op_b is used as normal.
- Undefined: op_chain is ignored and au_a always loads op_a.

Test Plan:
- Reset mid-ISSUE with op 1000, a=0x11, b=0x22 -> au_en=0, res_valid=0, op_cnt=0, op_ready=1 while rst is high.
- Add op 1000, a=0xF0, b=0x20, res_ready=1 -> au_en high for exactly cycle N+1; res_valid at N+2 with res_t=0x10, res_gf=0; op_cnt=1.
- Sub op 1001, a=0x03, b=0x05 -> res_t=0x02, res_gf=1. Then a=0x80, b=0x01 -> res_t=0x81, res_gf=1. Then a=0x01, b=0xFF -> res_t=0xFE, res_gf=0.
- Pass op 1101, a=0x5A, with res_ready held 0 for 5 cycles -> res_valid and res_t=0x5A stable throughout; second op_valid ignored; op_ready stays 0 until the handshake completes.
- Unsupported op 0011, with au_t driven X/Z -> au_en never asserts; res_err=1, res_t=0x00; op_cnt still increments.
- With AU_SEQ_CHAIN_EN defined: add 0x10+0x05, then chained add with op_a=0xFF, op_b=0x01 -> second au_a=0x15, res_t=0x16. Without the macro the second result is 0x00.

Source files
------------

// File: rtl/au_seq.sv
// au_seq: one-request-at-a-time sequencer feeding the 8-bit arithmetic unit.
// Optional feature macro: AU_SEQ_CHAIN_EN (op_chain selects the last good result as operand a).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   op_valid/op_ready                request handshake
//   op_code, op_a, op_b, op_chain    request payload
//   au_en, au_ac, au_a, au_b         AU drive, asserted for the single issue cycle
//   au_t, au_gf                      AU result, only sampled while au_en=1
//   res_valid/res_ready              result handshake
//   res_t, res_gf, res_err           captured result, greater flag, bad-opcode flag
//   op_cnt                           completed-transaction count, wraps
module au_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic             op_chain,
  output logic             au_en,
  output logic [3:0]       au_ac,
  output logic [7:0]       au_a,
  output logic [7:0]       au_b,
  input  logic [7:0]       au_t,
  input  logic             au_gf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_t,
  output logic             res_gf,
  output logic             res_err,
  output logic [CNT_W-1:0] op_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic err, err_n, op_ready_n, au_en_n, res_valid_n, res_gf_n, res_err_n;
  logic [3:0] au_ac_n;
  logic [7:0] au_a_n, au_b_n, res_t_n, a_sel;
  logic [CNT_W-1:0] op_cnt_n;
  function automatic logic supported(input logic [3:0] c);
    return c == 4'b1000 || c == 4'b1001 || c == 4'b0100 || c == 4'b0101 || c == 4'b1101;
  endfunction
`ifdef AU_SEQ_CHAIN_EN
  // Most recent successful result; error transactions leave it untouched.
  logic [7:0] last_t;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_t <= 8'h00;
    else if (state == ISSUE && !err) last_t <= au_t;
  assign a_sel = op_chain ? last_t : op_a;
`else
  logic chain_unused;
  assign chain_unused = op_chain;
  assign a_sel = op_a;
`endif
  always_comb begin
    state_n = state;
    op_ready_n = op_ready;
    au_en_n = au_en;
    au_ac_n = au_ac;
    au_a_n = au_a;
    au_b_n = au_b;
    err_n = err;
    res_valid_n = res_valid;
    res_t_n = res_t;
    res_gf_n = res_gf;
    res_err_n = res_err;
    op_cnt_n = op_cnt;
    case (state)
      IDLE: if (op_valid) begin
        state_n = ISSUE;
        op_ready_n = 1'b0;
        au_en_n = supported(op_code);
        au_ac_n = op_code;
        au_a_n = a_sel;
        au_b_n = op_b;
        err_n = !supported(op_code);
      end
      // au_en equals !err here, so au_t is only taken when the AU is driving it.
      ISSUE: begin
        state_n = HOLD;
        res_valid_n = 1'b1;
        au_en_n = 1'b0;
        au_ac_n = 4'b0000;
        res_t_n = err ? 8'h00 : au_t;
        res_gf_n = err ? 1'b0 : au_gf;
        res_err_n = err;
      end
      HOLD: if (res_ready) begin
        state_n = IDLE;
        op_ready_n = 1'b1;
        res_valid_n = 1'b0;
        res_err_n = 1'b0;
        op_cnt_n = op_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op_ready <= 1'b1;
      au_en <= 1'b0;
      au_ac <= 4'b0000;
      au_a <= 8'h00;
      au_b <= 8'h00;
      err <= 1'b0;
      res_valid <= 1'b0;
      res_t <= 8'h00;
      res_gf <= 1'b0;
      res_err <= 1'b0;
      op_cnt <= '0;
    end else begin
      state <= state_n;
      op_ready <= op_ready_n;
      au_en <= au_en_n;
      au_ac <= au_ac_n;
      au_a <= au_a_n;
      au_b <= au_b_n;
      err <= err_n;
      res_valid <= res_valid_n;
      res_t <= res_t_n;
      res_gf <= res_gf_n;
      res_err <= res_err_n;
      op_cnt <= op_cnt_n;
    end
endmodule

// File: tb/tb_au_seq.sv
// tb_au_seq: randomized and directed checks of au_seq against a behavioural reference.
module tb_au_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic op_valid = 1'b0, op_chain = 1'b0, res_ready = 1'b0;
  logic [3:0] op_code = 4'h0;
  logic [7:0] op_a = 8'h00, op_b = 8'h00;
  logic op_ready, au_en, au_gf, res_valid, res_gf, res_err;
  logic [3:0] au_ac;
  logic [7:0] au_a, au_b, au_t, res_t;
  logic [7:0] op_cnt;
  logic [8:0] au_res;
  int n_assert = 0, n_fail = 0;
  int m_cnt = 0;
  logic [7:0] m_last = 8'h00;
`ifdef AU_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  au_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_chain(op_chain), .au_en(au_en), .au_ac(au_ac),
    .au_a(au_a), .au_b(au_b), .au_t(au_t), .au_gf(au_gf), .res_valid(res_valid),
    .res_ready(res_ready), .res_t(res_t), .res_gf(res_gf), .res_err(res_err), .op_cnt(op_cnt)
  );
  always #5 clk = ~clk;
  function automatic bit is_sup(input logic [3:0] c);
    return c inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd13};
  endfunction
  // Returns {gf, t} from plain integer arithmetic on the opcode rules.
  function automatic logic [8:0] ref_op(input logic [3:0] c, input logic [7:0] a, b);
    int ia, ib, sa, sb, t;
    bit gf;
    ia = int'(a);
    ib = int'(b);
    sa = ia >= 128 ? ia - 256 : ia;
    sb = ib >= 128 ? ib - 256 : ib;
    t = 0;
    gf = 1'b0;
    if (c == 4'd8) t = (ia + ib) % 256;
    else if (c == 4'd9) begin
      t = (ib - ia + 256) % 256;
      gf = sb > sa;
    end else if (is_sup(c)) t = ia;
    return {gf, t[7:0]};
  endfunction
  always_comb au_res = ref_op(au_ac, au_a, au_b);
  assign au_t = au_en ? au_res[7:0] : 8'hzz;
  assign au_gf = au_en ? au_res[8] : 1'bz;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [3:0] c, input logic [7:0] a, b, input logic ch, input int hold);
    logic [7:0] ea, et;
    logic [8:0] r;
    logic eg, ee;
    ee = !is_sup(c);
    ea = (CHAIN && ch) ? m_last : a;
    r = ref_op(c, ea, b);
    et = ee ? 8'h00 : r[7:0];
    eg = ee ? 1'b0 : r[8];
    if (!ee) m_last = et;
    chk("ready_idle", 16'(op_ready), 16'h1);
    op_valid = 1'b1;
    op_code = c;
    op_a = a;
    op_b = b;
    op_chain = ch;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code = 4'($urandom);
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    chk("issue_en", 16'(au_en), 16'(!ee));
    chk("issue_ac", 16'(au_ac), 16'(c));
    chk("issue_a", 16'(au_a), 16'(ea));
    chk("issue_b", 16'(au_b), 16'(b));
    chk("issue_ready", 16'(op_ready), 16'h0);
    chk("issue_valid", 16'(res_valid), 16'h0);
    @(posedge clk); #1;
    chk("res_valid", 16'(res_valid), 16'h1);
    chk("res_en_off", 16'(au_en), 16'h0);
    chk("res_ac_off", 16'(au_ac), 16'h0);
    chk("res_t", 16'(res_t), 16'(et));
    chk("res_gf", 16'(res_gf), 16'(eg));
    chk("res_err", 16'(res_err), 16'(ee));
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1;
      op_code = 4'd8;
      op_a = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 16'(res_valid), 16'h1);
      chk("hold_t", 16'(res_t), 16'(et));
      chk("hold_gf", 16'(res_gf), 16'(eg));
      chk("hold_err", 16'(res_err), 16'(ee));
      chk("hold_ready", 16'(op_ready), 16'h0);
      chk("hold_en", 16'(au_en), 16'h0);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    m_cnt = (m_cnt + 1) % 256;
    chk("done_valid", 16'(res_valid), 16'h0);
    chk("done_err", 16'(res_err), 16'h0);
    chk("done_ready", 16'(op_ready), 16'h1);
    chk("done_cnt", 16'(op_cnt), 16'(m_cnt));
    chk("done_t_kept", 16'(res_t), 16'(et));
  endtask
  initial begin
    logic [3:0] sup_tab [5];
    sup_tab = '{4'd4, 4'd5, 4'd8, 4'd9, 4'd13};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 16'(op_ready), 16'h1);
    chk("rst_en", 16'(au_en), 16'h0);
    chk("rst_ac", 16'(au_ac), 16'h0);
    chk("rst_a", 16'(au_a), 16'h0);
    chk("rst_b", 16'(au_b), 16'h0);
    chk("rst_valid", 16'(res_valid), 16'h0);
    chk("rst_t", 16'(res_t), 16'h0);
    chk("rst_gf", 16'(res_gf), 16'h0);
    chk("rst_err", 16'(res_err), 16'h0);
    chk("rst_cnt", 16'(op_cnt), 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(4'b1000, 8'hF0, 8'h20, 1'b0, 0);
    do_op(4'b1001, 8'h03, 8'h05, 1'b0, 0);
    do_op(4'b1001, 8'h80, 8'h01, 1'b0, 1);
    do_op(4'b1001, 8'h01, 8'hFF, 1'b0, 0);
    do_op(4'b1101, 8'h5A, 8'h33, 1'b0, 5);
    do_op(4'b0011, 8'h77, 8'h88, 1'b0, 2);
    do_op(4'b1000, 8'h10, 8'h05, 1'b0, 0);
    do_op(4'b1000, 8'hFF, 8'h01, 1'b1, 0);
    op_valid = 1'b1;
    op_code = 4'b1000;
    op_a = 8'h11;
    op_b = 8'h22;
    op_chain = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("pre_abort_en", 16'(au_en), 16'h1);
    rst = 1'b1;
    #1;
    chk("abort_en", 16'(au_en), 16'h0);
    chk("abort_valid", 16'(res_valid), 16'h0);
    chk("abort_cnt", 16'(op_cnt), 16'h0);
    chk("abort_ready", 16'(op_ready), 16'h1);
    @(posedge clk); #1;
    chk("abort_hold_valid", 16'(res_valid), 16'h0);
    chk("abort_hold_en", 16'(au_en), 16'h0);
    rst = 1'b0;
    m_cnt = 0;
    m_last = 8'h00;
    @(posedge clk); #1;
    do_op(4'b1000, 8'h01, 8'h02, 1'b1, 0);
    for (int k = 0; k < 40; k++) begin
      logic [3:0] c;
      c = $urandom_range(0, 2) != 0 ? sup_tab[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
      do_op(c, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
